// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-ported memory between instruction fetch (IF) and data (DM) requesters.
// Latency: request/grant and response forwarding are combinational; minimum transaction is 2 cycles.
// Backpressure: requesters hold req until their gnt pulse; i_mem_gnt stalls the locked request in REQ.
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                    i_if_flush,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,

    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic                    o_dm_gnt,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,

    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,

    output logic                    o_busy,
    output logic                    o_err
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int SW   = $clog2(MAX_DATA_STREAK + 1);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic SEL_DM = 1'b0;
    localparam logic SEL_IF = 1'b1;

    logic [1:0]    state_q,  state_d;
    logic          sel_q,    sel_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          drop_q,   drop_d;
    logic          err_q,    err_d;

    logic win_if;
    logic any_req;
    logic cur_sel;
    logic mem_req;
    logic gnt_fire;
    logic rsp_fire;
    logic flush_hit;

    // Pick the owner of the memory port for this cycle: IDLE arbitrates, REQ/RSP keep the lock.
    always_comb begin
        any_req = i_if_req | i_dm_req;
        // DM has priority; IF wins only when alone or once the DM streak has hit its limit.
        win_if  = i_if_req & (~i_dm_req | (streak_q == STREAK_MAX));
        cur_sel = (state_q == ST_IDLE) ? win_if : sel_q;

        // Reset suppresses all requests and responses so nothing leaks out while it is held.
        mem_req  = ~i_rst & (((state_q == ST_IDLE) & any_req) | (state_q == ST_REQ));
        gnt_fire = mem_req & i_mem_gnt;
        rsp_fire = ~i_rst & (state_q == ST_RSP) & i_mem_rvalid;

        // A flush only matters once an IF transaction is committed: locked, granted or in flight.
        flush_hit = i_if_flush &
                    (((sel_q == SEL_IF) & ((state_q == ST_REQ) | (state_q == ST_RSP))) |
                     (gnt_fire & (cur_sel == SEL_IF)));
    end

    // Drive the selected requester's payload; outputs stay zero when no request is presented.
    always_comb begin
        o_mem_req   = mem_req;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (mem_req) begin
            if (cur_sel == SEL_IF) begin
                o_mem_addr = i_if_addr;
                o_mem_be   = {BE_W{1'b1}};
            end else begin
                o_mem_we    = i_dm_we;
                o_mem_addr  = i_dm_addr;
                o_mem_wdata = i_dm_wdata;
                o_mem_be    = i_dm_be;
            end
        end
    end

    // Route grant and response strobes back to the owning requester.
    always_comb begin
        o_if_gnt    = gnt_fire & (cur_sel == SEL_IF);
        o_dm_gnt    = gnt_fire & (cur_sel == SEL_DM);
        // A flush arriving together with the response must also suppress it.
        o_if_rvalid = rsp_fire & (sel_q == SEL_IF) & ~drop_q & ~i_if_flush;
        o_dm_rvalid = rsp_fire & (sel_q == SEL_DM);
        o_if_rdata  = i_mem_rdata;
        o_dm_rdata  = i_mem_rdata;
        o_busy      = (state_q != ST_IDLE);
        o_err       = err_q;
    end

    // Next-state logic for the FSM and the arbitration bookkeeping registers.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        streak_d = streak_q;
        drop_d   = drop_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    sel_d   = cur_sel;
                    state_d = i_mem_gnt ? ST_RSP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_gnt) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count DM wins only while IF is actually waiting; an IF win clears the debt.
        if (gnt_fire) begin
            if (cur_sel == SEL_IF) begin
                streak_d = '0;
            end else if (i_if_req && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + STREAK_ONE;
            end
        end

        if (flush_hit) begin
            drop_d = 1'b1;
        end
        // Drop state belongs to one transaction; it dies with the response.
        if ((state_q == ST_RSP) && i_mem_rvalid) begin
            drop_d = 1'b0;
        end

        // A response with nothing outstanding is a protocol error.
        if (i_mem_rvalid && (state_q != ST_RSP)) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset forgets any outstanding transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_DM;
            streak_q <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter, cycle vectors plus a contention sequence.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory, driving i_mem_gnt / i_mem_rvalid per vector.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .i_dm_be(dm_be), .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_err(err)
    );

    typedef struct packed {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        fl;
        logic        dmr;
        logic        we;
        logic [31:0] dma;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        g;
        logic        rv;
        logic [31:0] rd;
    } in_t;

    typedef struct packed {
        logic        mreq;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic        ifg;
        logic        dmg;
        logic        ifrv;
        logic        dmrv;
        logic        busy;
        logic        err;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    logic own_q[$];

    function automatic in_t vi(logic r, logic ifr, logic [31:0] ifa, logic fl, logic dmr,
                               logic we, logic [31:0] dma, logic [31:0] wd, logic [3:0] be,
                               logic g, logic rv, logic [31:0] rd);
        in_t v;
        v.rst = r;  v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.dmr = dmr; v.we = we;
        v.dma = dma; v.wd = wd;  v.be = be;   v.g = g;   v.rv = rv;   v.rd = rd;
        return v;
    endfunction

    function automatic exp_t ve(logic mreq, logic [31:0] maddr, logic mwe, logic [3:0] mbe,
                                logic [31:0] mwd, logic ifg, logic dmg, logic ifrv,
                                logic dmrv, logic b, logic e);
        exp_t x;
        x.mreq = mreq; x.maddr = maddr; x.mwe = mwe; x.mbe = mbe; x.mwd = mwd;
        x.ifg = ifg; x.dmg = dmg; x.ifrv = ifrv; x.dmrv = dmrv; x.busy = b; x.err = e;
        return x;
    endfunction

    task automatic add(in_t i, exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic apply(in_t v);
        rst = v.rst;  if_req = v.ifr; if_addr = v.ifa; if_flush = v.fl;
        dm_req = v.dmr; dm_we = v.we; dm_addr = v.dma; dm_wdata = v.wd; dm_be = v.be;
        mem_gnt = v.g; mem_rvalid = v.rv; mem_rdata = v.rd;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        in_t  z;
        logic exp_if;

        z = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset state
        add(vi(1,0,0,0,0,0,0,0,0,0,0,0),             ve(0,0,0,0,0,0,0,0,0,0,0));
        // lone fetch
        add(vi(0,1,'h100,0,0,0,0,0,0,1,0,0),         ve(1,'h100,0,'hF,0,1,0,0,0,0,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'hDEADBEEF),    ve(0,0,0,0,0,0,0,1,0,1,0));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,0));
        // locked selection: gnt withheld, DM arrives while IF is locked
        add(vi(0,1,'h104,0,0,0,0,0,0,0,0,0),         ve(1,'h104,0,'hF,0,0,0,0,0,0,0));
        add(vi(0,1,'h104,0,1,0,'h300,0,'hF,0,0,0),   ve(1,'h104,0,'hF,0,0,0,0,0,1,0));
        add(vi(0,1,'h104,0,1,0,'h300,0,'hF,0,0,0),   ve(1,'h104,0,'hF,0,0,0,0,0,1,0));
        add(vi(0,1,'h104,0,1,0,'h300,0,'hF,1,0,0),   ve(1,'h104,0,'hF,0,1,0,0,0,1,0));
        add(vi(0,0,0,0,1,0,'h300,0,'hF,0,1,'h11),    ve(0,0,0,0,0,0,0,1,0,1,0));
        add(vi(0,0,0,0,1,0,'h300,0,'hF,1,0,0),       ve(1,'h300,0,'hF,0,0,1,0,0,0,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h22),          ve(0,0,0,0,0,0,0,0,1,1,0));
        // flush in RSP, then DM store
        add(vi(0,1,'h108,0,0,0,0,0,0,1,0,0),         ve(1,'h108,0,'hF,0,1,0,0,0,0,0));
        add(vi(0,0,0,1,0,0,0,0,0,0,0,0),             ve(0,0,0,0,0,0,0,0,0,1,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h33),          ve(0,0,0,0,0,0,0,0,0,1,0));
        add(vi(0,0,0,0,1,1,'h200,'hCAFEF00D,'h3,1,0,0), ve(1,'h200,1,'h3,'hCAFEF00D,0,1,0,0,0,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h44),          ve(0,0,0,0,0,0,0,0,1,1,0));
        // flush coinciding with rvalid
        add(vi(0,1,'h10C,0,0,0,0,0,0,1,0,0),         ve(1,'h10C,0,'hF,0,1,0,0,0,0,0));
        add(vi(0,0,0,1,0,0,0,0,0,0,1,'h55),          ve(0,0,0,0,0,0,0,0,0,1,0));
        // flush in the IF grant cycle
        add(vi(0,1,'h110,1,0,0,0,0,0,1,0,0),         ve(1,'h110,0,'hF,0,1,0,0,0,0,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h56),          ve(0,0,0,0,0,0,0,0,0,1,0));
        // flush has no effect on a DM owner
        add(vi(0,0,0,1,1,0,'h204,0,'hF,1,0,0),       ve(1,'h204,0,'hF,0,0,1,0,0,0,0));
        add(vi(0,0,0,1,0,0,0,0,0,0,1,'h66),          ve(0,0,0,0,0,0,0,0,1,1,0));
        // spurious response in IDLE, sticky err, cleared by reset
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h99),          ve(0,0,0,0,0,0,0,0,0,0,0));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,1));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,1));
        add(vi(1,0,0,0,0,0,0,0,0,0,0,0),             ve(0,0,0,0,0,0,0,0,0,0,1));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,0));
        // reset in RSP with DM owner, late rvalid is not forwarded
        add(vi(0,0,0,0,1,0,'h208,0,'hF,1,0,0),       ve(1,'h208,0,'hF,0,0,1,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0,0,0,0),             ve(0,0,0,0,0,0,0,0,0,1,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h77),          ve(0,0,0,0,0,0,0,0,0,0,0));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,1));
        add(vi(1,0,0,0,0,0,0,0,0,0,0,0),             ve(0,0,0,0,0,0,0,0,0,0,1));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,0));
        // flush while IF waits in REQ
        add(vi(0,1,'h114,0,0,0,0,0,0,0,0,0),         ve(1,'h114,0,'hF,0,0,0,0,0,0,0));
        add(vi(0,1,'h114,1,0,0,0,0,0,0,0,0),         ve(1,'h114,0,'hF,0,0,0,0,0,1,0));
        add(vi(0,1,'h114,0,0,0,0,0,0,1,0,0),         ve(1,'h114,0,'hF,0,1,0,0,0,1,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h88),          ve(0,0,0,0,0,0,0,0,0,1,0));
        add(z,                                        ve(0,0,0,0,0,0,0,0,0,0,0));
        // drop does not leak into the next fetch
        add(vi(0,1,'h118,0,0,0,0,0,0,1,0,0),         ve(1,'h118,0,'hF,0,1,0,0,0,0,0));
        add(vi(0,0,0,0,0,0,0,0,0,0,1,'h1234ABCD),    ve(0,0,0,0,0,0,0,1,0,1,0));

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            apply(tbl[r].i);
            sb.push_back(tbl[r].e);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("r%0d.mem_req", r),   32'(mem_req),    32'(e.mreq));
            chk($sformatf("r%0d.mem_addr", r),  mem_addr,        e.maddr);
            chk($sformatf("r%0d.mem_we", r),    32'(mem_we),     32'(e.mwe));
            chk($sformatf("r%0d.mem_be", r),    32'(mem_be),     32'(e.mbe));
            chk($sformatf("r%0d.mem_wdata", r), mem_wdata,       e.mwd);
            chk($sformatf("r%0d.if_gnt", r),    32'(if_gnt),     32'(e.ifg));
            chk($sformatf("r%0d.dm_gnt", r),    32'(dm_gnt),     32'(e.dmg));
            chk($sformatf("r%0d.if_rvalid", r), 32'(if_rvalid),  32'(e.ifrv));
            chk($sformatf("r%0d.dm_rvalid", r), 32'(dm_rvalid),  32'(e.dmrv));
            chk($sformatf("r%0d.busy", r),      32'(busy),       32'(e.busy));
            chk($sformatf("r%0d.err", r),       32'(err),        32'(e.err));
            if (tbl[r].i.rv) begin
                chk($sformatf("r%0d.if_rdata", r), if_rdata, tbl[r].i.rd);
                chk($sformatf("r%0d.dm_rdata", r), dm_rdata, tbl[r].i.rd);
            end
        end

        // contention: both requesters held, memory always ready; IF wins every 5th grant
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            apply(vi(0,1,'h400,0,1,0,'h500,0,'hF,1,0,0));
            own_q.push_back(k % 5 == 4);
            @(negedge clk);
            exp_if = own_q.pop_front();
            chk($sformatf("s%0d.if_gnt", k),   32'(if_gnt),   32'(exp_if));
            chk($sformatf("s%0d.dm_gnt", k),   32'(dm_gnt),   32'(!exp_if));
            chk($sformatf("s%0d.mem_addr", k), mem_addr,      exp_if ? 32'h400 : 32'h500);
            @(posedge clk);
            #1;
            apply(vi(0,1,'h400,0,1,0,'h500,0,'hF,1,1,32'(k)));
            @(negedge clk);
            chk($sformatf("s%0d.if_rvalid", k), 32'(if_rvalid), 32'(exp_if));
            chk($sformatf("s%0d.dm_rvalid", k), 32'(dm_rvalid), 32'(!exp_if));
        end

        @(posedge clk);
        #1;
        apply(z);
        @(negedge clk);
        chk("end.busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the CPU's single-ported unified memory between the instruction-fetch (IF) requester and the data-memory (DM, MEM-stage load/store) requester. Sits between the pipeline front/back ends and the memory interface. Carries one transaction at a time through a req/gnt + rvalid protocol. Uses fixed data-first priority with a bounded-starvation guarantee for fetch, and discards fetch responses that a pipeline flush has made stale.

## Interface

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- MAX_DATA_STREAK, 4, consecutive DM grants allowed while IF is waiting before IF wins once (≥1)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; held until o_if_gnt
- i_if_addr  in  ADDR_WIDTH  fetch address
- i_if_flush  in  1  pipeline flush; cancels the response of an in-flight fetch
- o_if_gnt  out  1  fetch accepted by memory (1-cycle pulse)
- o_if_rvalid  out  1  fetch response valid
- o_if_rdata  out  DATA_WIDTH  fetch data (= i_mem_rdata)
- i_dm_req  in  1  data request; held until o_dm_gnt
- i_dm_we  in  1  1 = store
- i_dm_addr  in  ADDR_WIDTH  data address
- i_dm_wdata  in  DATA_WIDTH  store data
- i_dm_be  in  DATA_WIDTH/8  byte enables
- o_dm_gnt  out  1  data request accepted (1-cycle pulse)
- o_dm_rvalid  out  1  data response valid (loads and stores)
- o_dm_rdata  out  DATA_WIDTH  load data (= i_mem_rdata)
- o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  request to memory
- i_mem_gnt  in  1  memory accepts request this cycle
- i_mem_rvalid  in  1  response valid; exactly one per accepted request
- i_mem_rdata  in  DATA_WIDTH  response data
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky: unexpected i_mem_rvalid

## Operation

- FSM states: IDLE, REQ (selection locked, awaiting gnt), RSP (awaiting rvalid). Registers: sel (IF/DM), streak counter (width $clog2(MAX_DATA_STREAK+1)), drop flag, err.
- Selection in IDLE: if only one requester is active, that requester wins. If both are active, DM wins, unless streak == MAX_DATA_STREAK, in which case IF wins.
- IDLE, any req: drive the winner's payload on o_mem_* with o_mem_req=1 (IF: we=0, be=all-ones, wdata=0). Store the winner in sel. If i_mem_gnt → RSP, else → REQ.
- REQ: drive the locked sel's payload with o_mem_req=1. The selection must not change even if a higher-priority requester arrives. On i_mem_gnt → RSP.
- Grant cycle: assert o_if_gnt or o_dm_gnt for sel. Streak update: DM grant while i_if_req=1 → streak+1, saturating; any IF grant → 0; DM grant with i_if_req=0 → unchanged.
- RSP: o_mem_req=0. On i_mem_rvalid, assert the sel owner's rvalid (gated by drop), then → IDLE. A new request is accepted from IDLE no earlier than the next cycle.
- Flush: drop is set if i_if_flush=1 while sel=IF in REQ or RSP, or in the IF grant cycle. When drop is set, o_if_rvalid is suppressed, including when i_if_flush coincides with i_mem_rvalid. drop is cleared on entering IDLE. Flush has no effect on a DM owner, or in IDLE with no IF grant.
- i_mem_rvalid in IDLE or REQ: ignored for routing; sets err. err is sticky until reset.
- Reset mid-transaction: the FSM returns to IDLE and any pending response is forgotten. The memory shares i_rst.

## Timing

- Reset values: state=IDLE, sel=DM, streak=0, drop=0, err=0. All outputs 0, except o_*_rdata, which follow i_mem_rdata.
- IDLE request → o_mem_req is combinational, in the same cycle. gnt → o_*_gnt is combinational, in the same cycle.
- i_mem_rvalid → o_*_rvalid is combinational, in the same cycle.
- Minimum transaction: 2 cycles (grant cycle + rvalid cycle). Peak throughput: 1 transaction per 2 cycles.
- o_mem_* payload is stable from the first o_mem_req cycle until gnt.

## Test plan

- Lone fetch: i_if_req addr=0x100, gnt immediately, rvalid next cycle with 0xDEADBEEF → o_if_gnt in cycle 0, o_if_rvalid + o_if_rdata=0xDEADBEEF in cycle 1, o_busy high only in cycle 1.
- Contention and starvation (MAX_DATA_STREAK=4): both requesters held continuously → grant order DM,DM,DM,DM,IF,DM…; streak returns to 0 after the IF grant.
- Locked selection: IF request, i_mem_gnt withheld 3 cycles, DM request raised in cycle 1 → o_mem_addr stays the IF address; IF is granted first, DM next.
- Flush: IF granted, i_if_flush pulsed in RSP (also repeat with flush in the same cycle as rvalid) → o_if_rvalid stays 0; next DM store 0x200, be=0x3, gets o_dm_rvalid normally.
- Spurious response: i_mem_rvalid in IDLE → no rvalid on either port; o_err=1 and held; i_rst for 1 cycle → o_err=0.
- Reset in RSP with DM owner: i_rst, then i_mem_rvalid → o_dm_rvalid=0, state=IDLE.
